// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART receiver types, baud-select encoding, bit periods.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] c_SEL_9600  = 2'b00;
    localparam logic [1:0] c_SEL_19200 = 2'b01;
    localparam logic [1:0] c_SEL_38400 = 2'b10;
    localparam logic [1:0] c_SEL_57600 = 2'b11;

    // Clocks per bit at a 576 kHz system clock.
    localparam logic [5:0] c_P_9600  = 6'd60;
    localparam logic [5:0] c_P_19200 = 6'd30;
    localparam logic [5:0] c_P_38400 = 6'd15;
    localparam logic [5:0] c_P_57600 = 6'd10;

    function automatic logic [5:0] bit_period(input logic [1:0] i_sel);
        logic [5:0] w_p;
        case (i_sel)
            c_SEL_9600:  w_p = c_P_9600;
            c_SEL_19200: w_p = c_P_19200;
            c_SEL_38400: w_p = c_P_38400;
            default:     w_p = c_P_57600;
        endcase
        return w_p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module   : uart_sync
// Purpose  : SYNC_STAGES-deep flip-flop synchronizer, resets to idle-high.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_sync <= 1'b1;
                end else begin
                    r_sync <= i_d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampled UART receiver, 4 selectable baud rates, LSB first.
//            Optional even parity enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           sel,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int               c_BCW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BIT = c_BCW'(DATA_BITS - 1);

    state_t                 r_state,  w_state;
    logic [5:0]             r_cnt,    w_cnt;
    logic [c_BCW-1:0]       r_bitcnt, w_bitcnt;
    logic [DATA_BITS-1:0]   r_shift,  w_shift;
    logic [DATA_BITS-1:0]   r_data,   w_data;
    logic                   r_valid,  w_valid;
    logic                   r_ferr,   w_ferr;
    logic [1:0]             r_sel,    w_sel;
    logic                   r_armed,  w_armed;

    logic                   w_rxs;
    logic [5:0]             w_period;
    logic [5:0]             w_half;
    logic                   w_bit_tick;
    logic                   w_half_tick;
    logic                   w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit, w_par_bit;
    logic                   r_perr,    w_perr;
`endif

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    assign w_period    = bit_period(r_sel);
    assign w_half      = w_period >> 1;
    assign w_bit_tick  = (r_cnt == w_period - 6'd1);
    assign w_half_tick = (r_cnt == w_half - 6'd1);

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = (^r_shift) != r_par_bit;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_sel    <= c_SEL_9600;
            r_armed  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bitcnt <= w_bitcnt;
            r_shift  <= w_shift;
            r_data   <= w_data;
            r_valid  <= w_valid;
            r_ferr   <= w_ferr;
            r_sel    <= w_sel;
            r_armed  <= w_armed;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= w_par_bit;
            r_perr    <= w_perr;
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bitcnt = r_bitcnt;
        w_shift  = r_shift;
        w_data   = r_data;
        w_valid  = 1'b0;
        w_ferr   = 1'b0;
        w_sel    = r_sel;
        w_armed  = r_armed;
`ifdef UART_RX_PARITY_EN
        w_par_bit = r_par_bit;
        w_perr    = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                w_cnt    = '0;
                w_bitcnt = '0;
                // A start edge is honoured only after the line has been seen high.
                if (!w_rxs && r_armed) begin
                    w_state = ST_START;
                    w_sel   = sel;
                    w_armed = 1'b0;
                end else if (w_rxs) begin
                    w_armed = 1'b1;
                end
            end

            ST_START: begin
                if (w_half_tick) begin
                    w_cnt = '0;
                    if (w_rxs) begin
                        w_state = ST_IDLE;
                        w_armed = 1'b1;
                    end else begin
                        w_state  = ST_DATA;
                        w_bitcnt = '0;
                    end
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end

            ST_DATA: begin
                if (w_bit_tick) begin
                    w_cnt             = '0;
                    w_shift[r_bitcnt] = w_rxs;
                    if (r_bitcnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state = ST_PARITY;
`else
                        w_state = ST_STOP;
`endif
                    end else begin
                        w_bitcnt = r_bitcnt + 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_cnt     = '0;
                    w_par_bit = w_rxs;
                    w_state   = ST_STOP;
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end
`endif

            ST_STOP: begin
                if (w_bit_tick) begin
                    w_cnt   = '0;
                    w_data  = r_shift;
                    w_valid = w_rxs & ~w_par_bad;
                    w_ferr  = ~w_rxs;
`ifdef UART_RX_PARITY_EN
                    w_perr  = w_par_bad;
`endif
                    w_state = ST_IDLE;
                    // A good stop bit counts as idle line, allowing a start in the next cycle.
                    w_armed = w_rxs;
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Randomised self-checking bench for uart_rx against a frame-level
//            reference model. Honours UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [1:0] sel   = 2'b00;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       perr_mon;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc        = 0;
    logic prev_pulse = 1'b0;

    logic [2:0] ev_kind[$];
    logic [7:0] ev_data[$];
    int         ev_cyc[$];
    logic [2:0] exp_kind[$];
    logic [7:0] exp_data[$];
    int         exp_t0[$];
    int         exp_lat[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef UART_RX_PARITY_EN
    logic parity_err;
    assign perr_mon = parity_err;
`else
    assign perr_mon = 1'b0;
`endif

    uart_rx #(
        .DATA_BITS   (DATA_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Pulse kind is {parity_err, frame_err, valid}.
    always @(negedge clk) begin
        if (valid || frame_err || perr_mon) begin
            ev_kind.push_back({perr_mon, frame_err, valid});
            ev_data.push_back(data);
            ev_cyc.push_back(cyc);
            chk("valid_ferr_excl", 32'(valid & frame_err), 32'd0);
            chk("pulse_width", 32'(prev_pulse), 32'd0);
        end
        prev_pulse <= valid | frame_err | perr_mon;
    end

    function automatic int per_of(input logic [1:0] s);
        case (s)
            2'b00:   return 60;
            2'b01:   return 30;
            2'b10:   return 15;
            default: return 10;
        endcase
    endfunction

    function automatic logic par_of(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb,
                              input int gap, input int low_hold, input int sel_mid,
                              input int abort_bit);
        int   p;
        int   lat;
        logic par_ok;
        p      = per_of(sel);
        par_ok = PARITY_EN ? (parb == par_of(d)) : 1'b1;
        lat    = p / 2 + (DATA_BITS + 1) * p + SYNC_STAGES + 1 + (PARITY_EN ? p : 0);
        @(negedge clk);
        rx = 1'b0;
        if (abort_bit < 0) begin
            exp_kind.push_back({~par_ok, ~stopb, stopb & par_ok});
            exp_data.push_back(d);
            exp_t0.push_back(cyc);
            exp_lat.push_back(lat);
        end
        repeat (p) @(negedge clk);
        if (sel_mid >= 0) sel = 2'(sel_mid);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                repeat (p / 2) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                rx    = 1'b1;
                chk("rst_mid_data", 32'(data), 32'd0);
                chk("rst_mid_valid", 32'(valid), 32'd0);
                chk("rst_mid_ferr", 32'(frame_err), 32'd0);
                chk("rst_mid_busy", 32'(busy), 32'd0);
                return;
            end
            repeat (p) @(negedge clk);
        end
        if (PARITY_EN) begin
            rx = parb;
            repeat (p) @(negedge clk);
        end
        rx = stopb;
        repeat (p) @(negedge clk);
        if (low_hold > 0) begin
            rx = 1'b0;
            repeat (low_hold) @(negedge clk);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int         waited;
        int         c;
        int         t0;
        int         el;
        logic [2:0] k;
        logic [2:0] ek;
        logic [7:0] dd;
        logic [7:0] ed;
        waited = 0;
        while (ev_kind.size() < exp_kind.size() && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        chk("event_count", 32'(ev_kind.size()), 32'(exp_kind.size()));
        while (exp_kind.size() > 0 && ev_kind.size() > 0) begin
            k  = ev_kind.pop_front();
            dd = ev_data.pop_front();
            c  = ev_cyc.pop_front();
            ek = exp_kind.pop_front();
            ed = exp_data.pop_front();
            t0 = exp_t0.pop_front();
            el = exp_lat.pop_front();
            chk("pulse_kind", 32'(k), 32'(ek));
            chk("frame_data", 32'(dd), 32'(ed));
            chk("latency_window", 32'((c - t0 >= el - 1) && (c - t0 <= el + 1)), 32'd1);
        end
        exp_kind.delete(); exp_data.delete(); exp_t0.delete(); exp_lat.delete();
        ev_kind.delete();  ev_data.delete();  ev_cyc.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         waited;
        int         p;
        int         rgap;
        int         rmid;
        logic [7:0] rd;
        logic       rstop;
        logic       rbad;

        repeat (4) @(negedge clk);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        sel = 2'b00;
        send_frame(8'hA5, 1'b1, par_of(8'hA5), 20, 0, -1, -1);
        drain(200);

        sel = 2'b11;
        send_frame(8'h00, 1'b1, par_of(8'h00), 0, 0, -1, -1);
        send_frame(8'hFF, 1'b1, par_of(8'hFF), 5, 0, -1, -1);
        drain(50);

        // Short low pulse must be rejected as a glitch.
        sel = 2'b00;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_high", 32'(busy), 32'd1);
        rx = 1'b1;
        waited = 0;
        while (busy && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        chk("glitch_busy_low", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("glitch_no_event", 32'(ev_kind.size()), 32'd0);

        sel = 2'b01;
        send_frame(8'h3C, 1'b0, par_of(8'h3C), 10, 60, -1, -1);
        drain(100);
        send_frame(8'h5A, 1'b1, par_of(8'h5A), 10, 0, -1, -1);
        drain(100);

        sel = 2'b10;
        send_frame(8'hC3, 1'b1, par_of(8'hC3), 10, 0, 0, -1);
        drain(100);

        sel = 2'b01;
        send_frame(8'h96, 1'b1, par_of(8'h96), 0, 0, -1, 4);
        repeat (40) @(negedge clk);
        drain(1);
        send_frame(8'h81, 1'b1, par_of(8'h81), 10, 0, -1, -1);
        drain(100);

`ifdef UART_RX_PARITY_EN
        sel = 2'b10;
        send_frame(8'h07, 1'b1, 1'b0, 10, 0, -1, -1);
        drain(100);
        send_frame(8'h07, 1'b1, 1'b1, 10, 0, -1, -1);
        drain(100);
`endif

        for (int i = 0; i < 20; i++) begin
            sel   = 2'($urandom_range(3));
            rd    = 8'($urandom);
            rstop = ($urandom_range(3) != 0);
            rbad  = ($urandom_range(3) == 0);
            p     = per_of(sel);
            rgap  = rstop ? int'($urandom_range(p)) : 2 + int'($urandom_range(p));
            rmid  = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
            send_frame(rd, rstop, par_of(rd) ^ rbad, rgap, 0, rmid, -1);
            drain(4 * p);
        end

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
